// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage_pkg                                              |
// | Description : Shared opcode constants, reset values and fetch FSM states.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPCODE_W = 5;

  // The decoder consumes these same opcode values.
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00001;

  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'b0};
  localparam logic [INSTR_W-1:0] RESET_PC  = 16'h0000;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_id_reg                                                    |
// | Description : IF/ID pipeline register with load-enable and NOP flush.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_id_reg #(
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [DATA_W-1:0] i_pc_plus2,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_pc_plus2,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc_plus2;
  logic              r_valid;

  // Flush wins over load; with neither asserted the register holds (stall).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus2 <= i_pc_plus2;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus2 = r_pc_plus2;
  assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage                                                  |
// | Description : PC, next-PC selection, halt FSM and IF/ID register.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage #(
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [DATA_W-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              halt_in,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [4:0]        if_id_opcode,
  output logic [DATA_W-1:0] if_id_pc_plus2,
  output logic              if_id_valid,
  output logic              halted
);

  import fetch_stage_pkg::*;

  localparam logic [DATA_W-1:0] C_PC_STEP  = DATA_W'(2);
  localparam logic [DATA_W-1:0] C_ALIGN    = ~DATA_W'(1);
  localparam logic [DATA_W-1:0] C_RESET_PC = RESET_PC & C_ALIGN;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_pc_plus2;
  logic [DATA_W-1:0] w_redirect_tgt;
  logic              w_load;
  logic              w_flush;

  // Wraps modulo 2^DATA_W with no carry out.
  assign w_pc_plus2     = r_pc + C_PC_STEP;
  assign w_redirect_tgt = redirect_pc & C_ALIGN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= C_RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Priority in RUN: halt > redirect > stall > normal fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt_in && if_id_valid) begin
          w_state_nxt = ST_HALTED;
          w_flush     = 1'b1;
        end else if (redirect) begin
          w_pc_nxt = w_redirect_tgt;
          w_flush  = 1'b1;
        end else if (!stall) begin
          w_pc_nxt = w_pc_plus2;
          w_load   = 1'b1;
        end
      end
      ST_HALTED: begin
        // Frozen until reset; all control inputs are ignored.
      end
      default: begin
        w_state_nxt = ST_HALTED;
        w_flush     = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (imem_data),
    .i_pc_plus2 (w_pc_plus2),
    .o_instr    (if_id_instr),
    .o_pc_plus2 (if_id_pc_plus2),
    .o_valid    (if_id_valid)
  );

  assign imem_addr    = r_pc;
  assign if_id_opcode = if_id_instr[DATA_W-1 -: 5];
  assign halted       = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                               |
// | Description : Scoreboard bench for fetch_stage against a behavioural model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [15:0] C_NOP = 16'h0800;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_in = 1'b0;
  logic [15:0] if_id_instr;
  logic [4:0]  if_id_opcode;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pp2;
  logic        m_valid;
  logic        m_halted;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h4001;
    if (a == 16'h0002) return 16'h4102;
    return {~a[15:8], a[7:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .if_id_instr    (if_id_instr),
    .if_id_opcode   (if_id_opcode),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 16'h0000;
    m_instr  = C_NOP;
    m_pp2    = 16'h0000;
    m_valid  = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},   imem_addr,       16'h0000);
    chk({tag, "_instr"},  if_id_instr,     C_NOP);
    chk({tag, "_pp2"},    if_id_pc_plus2,  16'h0000);
    chk({tag, "_valid"},  {15'b0, if_id_valid}, 16'h0000);
    chk({tag, "_halted"}, {15'b0, halted}, 16'h0000);
  endtask

  // Model the coming edge from the current inputs, then compare after it.
  task automatic run_cycle();
    exp_t e;
    if (!m_halted) begin
      if (halt_in && m_valid) begin
        m_halted = 1'b1;
        m_instr  = C_NOP;
        m_valid  = 1'b0;
      end else if (redirect) begin
        m_pc    = {redirect_pc[15:1], 1'b0};
        m_instr = C_NOP;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = mem_word(m_pc);
        m_pp2   = m_pc + 16'd2;
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd2;
      end
    end
    e.addr = m_pc; e.instr = m_instr; e.pp2 = m_pp2;
    e.valid = m_valid; e.halted = m_halted;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("imem_addr", imem_addr,   e.addr);
    chk("instr",     if_id_instr, e.instr);
    chk("opcode",    {11'b0, if_id_opcode}, {11'b0, e.instr[15:11]});
    chk("valid",     {15'b0, if_id_valid}, {15'b0, e.valid});
    chk("halted",    {15'b0, halted},      {15'b0, e.halted});
    if (e.valid) chk("pc_plus2", if_id_pc_plus2, e.pp2);
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] rpc, input logic h);
    stall = s; redirect = r; redirect_pc = rpc; halt_in = h;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Free run from reset.
    run_cycle();
    chk("edge1_instr", if_id_instr, 16'h4001);
    chk("edge1_pp2",   if_id_pc_plus2, 16'h0002);
    chk("edge1_addr",  imem_addr, 16'h0002);
    run_cycle();
    chk("edge2_instr", if_id_instr, 16'h4102);
    chk("edge2_pp2",   if_id_pc_plus2, 16'h0004);
    run_cycle();

    // Stall three edges at PC=6.
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk("stall_addr", imem_addr, 16'h0006);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    run_cycle();
    chk("resume_pp2", if_id_pc_plus2, 16'h0008);

    // Redirect while stalled; bit 0 of the target is dropped.
    drive(1'b1, 1'b1, 16'h0041, 1'b0);
    run_cycle();
    chk("redir_addr",  imem_addr, 16'h0040);
    chk("redir_instr", if_id_instr, C_NOP);
    // halt_in against an invalid IF/ID must be ignored.
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    run_cycle();
    chk("redir_tgt_instr", if_id_instr, mem_word(16'h0040));
    chk("redir_tgt_valid", {15'b0, if_id_valid}, 16'h0001);

    // Mixed random traffic.
    for (int i = 0; i < 24; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            16'($urandom_range(0, 16'h01FF)), 1'b0);
      run_cycle();
    end

    // Make sure IF/ID is valid, then halt.
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    run_cycle();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    run_cycle();
    chk("halt_flag",  {15'b0, halted}, 16'h0001);
    chk("halt_instr", if_id_instr, C_NOP);
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 1'b1, 16'h0100, i[1]);
      run_cycle();
    end
    chk("halt_frozen_addr", imem_addr, m_pc);

    // Asynchronous reset between edges while halted.
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    #2;
    check_reset_outputs("async_rst");
    rst = 1'b0;
    model_reset();
    run_cycle();
    chk("restart_instr", if_id_instr, 16'h4001);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0);
    run_cycle();
    chk("wrap_pre_addr", imem_addr, 16'hFFFE);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    run_cycle();
    chk("wrap_addr",  imem_addr, 16'h0000);
    chk("wrap_pp2",   if_id_pc_plus2, 16'h0000);
    chk("wrap_instr", if_id_instr, mem_word(16'hFFFE));
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-bit-opcode, 16-bit-instruction pipeline. Holds the PC, addresses a combinational-read instruction memory, and registers the fetched word into the IF/ID pipeline register that feeds the instruction decoder. Handles stall, branch/jump redirect with flush, and a sticky halt raised by the decoder.

## Interface
Parameters:
- `DATA_W`, 16: instruction and PC width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, 16'h0800: bubble word (opcode 5'b00001) injected on flush/halt.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  16  current PC, drives instruction memory.
- `imem_data`  in  16  instruction word at `imem_addr`, valid same cycle.
- `stall`  in  1  hazard stall from downstream; freeze PC and IF/ID.
- `redirect`  in  1  taken branch/jump resolved downstream.
- `redirect_pc`  in  16  target PC; bit 0 ignored (forced 0).
- `halt_in`  in  1  decoder's halt indication for the instruction in IF/ID.
- `if_id_instr`  out  16  registered instruction to decoder.
- `if_id_opcode`  out  5  `if_id_instr[15:11]`, wired to the decoder's opcode input.
- `if_id_pc_plus2`  out  16  registered PC+2 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real fetched instruction.
- `halted`  out  1  sticky; fetch stopped.

## Operation
- Two states: RUN, HALTED. Reset -> RUN.
- Reset values: PC=`RESET_PC`, `if_id_instr`=`NOP_INSTR`, `if_id_pc_plus2`=16'h0000, `if_id_valid`=0, `halted`=0.
- Per-edge priority in RUN: halt > redirect > stall > normal.
  - halt: `halt_in`=1 and `if_id_valid`=1 -> go HALTED, PC holds, IF/ID <= NOP, valid 0, `halted`=1. `halt_in` with valid=0 is ignored.
  - redirect: PC <= {redirect_pc[15:1],1'b0}; IF/ID <= NOP, valid 0 (flushes wrong-path fetch). Overrides stall.
  - stall: PC, IF/ID, valid all hold.
  - normal: IF/ID <= {imem_data, PC+2}, valid 1; PC <= PC+2.
- HALTED: PC and IF/ID frozen at NOP/valid 0; `redirect`, `stall`, `halt_in` ignored; exit only via `rst`.
- Arithmetic: PC+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000 with no flag.
- PC bit 0 is always 0.

## Timing
- `imem_addr` = PC register, purely combinational from state.
- Fetch latency: word at address A appears on `if_id_instr` one edge after PC=A.
- First instruction valid at the first rising edge after `rst` deasserts.
- Redirect penalty: one bubble; target word visible two edges after `redirect` sampled.
- `rst` asserted mid-operation: all outputs reach reset values immediately (asynchronous), regardless of state.
- `halted` rises on the same edge that loads the NOP.

## Structure
- Shared package: `OP_HALT`=5'b00000, `OP_NOP`=5'b00001, `NOP_INSTR`, `RESET_PC`, fetch state enum (RUN, HALTED); decoder consumes the same opcode constants.
- One sub-module: `if_id_reg` — IF/ID register with load-enable (hold on stall) and flush (load NOP, clear valid), async active-high reset.
- PC register, incrementer, next-PC mux and state FSM live in `fetch_stage` top.

## Test plan
- Reset then free-run with imem[0]=16'h4001, imem[2]=16'h4102: edge1 `if_id_instr`=16'h4001, pc_plus2=2; edge2 16'h4102, pc_plus2=4; `imem_addr` 0,2,4.
- Stall 3 cycles at PC=6: PC stays 6, `if_id_instr`/valid unchanged for 3 edges, resumes at 6 on release.
- Redirect to 16'h0041 while stalled: PC=16'h0040 next edge, IF/ID=16'h0800 valid 0, word at 0x40 valid following edge.
- `halt_in` with valid=1: `halted`=1, PC frozen, IF/ID=16'h0800 valid 0; subsequent redirect to 0x100 ignored for 10 cycles.
- PC at 16'hFFFE, no stall: next PC 16'h0000, `if_id_pc_plus2`=16'h0000.
- Assert `rst` between edges in HALTED: outputs return to reset values before next edge; fetch restarts at `RESET_PC`.
